// File: rtl/w0rm_peripheral_bus_merger_if.sv
// W0RM peripheral bus merger port bundle.
// The merger uses the master view. Sources and sink use the slave view.
interface w0rm_peripheral_bus_merger_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_PORTS  = 2
);
   logic [NUM_PORTS-1:0]            bus_port_valid_i;
   logic [NUM_PORTS*DATA_WIDTH-1:0] bus_port_data_i;
   logic [NUM_PORTS-1:0]            bus_port_ready_o;
   logic                            bus_valid_o;
   logic [DATA_WIDTH-1:0]           bus_data_o;
   logic [2:0]                      bus_port_id_o;
   logic                            bus_ready_i;

   modport master (
      input  bus_port_valid_i, bus_port_data_i, bus_ready_i,
      output bus_port_ready_o, bus_valid_o, bus_data_o, bus_port_id_o
   );

   modport slave (
      output bus_port_valid_i, bus_port_data_i, bus_ready_i,
      input  bus_port_ready_o, bus_valid_o, bus_data_o, bus_port_id_o
   );
endinterface

// File: rtl/w0rm_peripheral_bus_merger.sv
// W0RM peripheral bus merger: N input FIFOs with valid/ready handshakes.
// An arbiter (fixed priority or round-robin) drains the FIFOs into one
// registered output stage. Each output word carries the index of its source port.
module w0rm_peripheral_bus_merger #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_PORTS  = 2,
   parameter int FIFO_DEPTH = 2,
   parameter int ARB_MODE   = 1
) (
   input  logic                          bus_clock,
   input  logic                          bus_reset_n,
   w0rm_peripheral_bus_merger_if.master  bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [2:0]       LAST_RST = 3'(NUM_PORTS - 1);

   logic [DATA_WIDTH-1:0] mem_q   [NUM_PORTS][FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d   [NUM_PORTS][FIFO_DEPTH];
   logic [PTR_W-1:0]      wptr_q  [NUM_PORTS];
   logic [PTR_W-1:0]      wptr_d  [NUM_PORTS];
   logic [PTR_W-1:0]      rptr_q  [NUM_PORTS];
   logic [PTR_W-1:0]      rptr_d  [NUM_PORTS];
   logic [CNT_W-1:0]      count_q [NUM_PORTS];
   logic [CNT_W-1:0]      count_d [NUM_PORTS];

   logic [NUM_PORTS-1:0]  ready;
   logic [NUM_PORTS-1:0]  push;
   logic [NUM_PORTS-1:0]  pop;
   logic [NUM_PORTS-1:0]  nonempty;
   logic                  found;
   logic                  load;
   logic [2:0]            grant;
   logic [DATA_WIDTH-1:0] sel_data;

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [2:0]            id_q, id_d;
   logic [2:0]            last_q, last_d;

   // FIFO status from registered counts only, so ready has no path from bus_ready_i
   always_comb begin
      ready    = '0;
      push     = '0;
      nonempty = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         ready[p]    = (count_q[p] != FULL_CNT);
         nonempty[p] = (count_q[p] != '0);
         push[p]     = bus.bus_port_valid_i[p] && ready[p];
      end
   end

   // Arbiter: round-robin searches ports above last_grant first, then wraps to
   // the lowest index. Fixed priority uses only the wrap pass.
   always_comb begin
      grant    = '0;
      found    = 1'b0;
      pop      = '0;
      sel_data = '0;
      if (ARB_MODE == 1) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (!found && nonempty[p] && (3'(p) > last_q)) begin
               grant = 3'(p);
               found = 1'b1;
            end
         end
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (!found && nonempty[p]) begin
            grant = 3'(p);
            found = 1'b1;
         end
      end
      load = found && (!valid_q || bus.bus_ready_i);
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant == 3'(p)) begin
            sel_data = mem_q[p][rptr_q[p]];
            pop[p]   = load;
         end
      end
   end

   // FIFO next state. Pointers wrap naturally because they are exactly log2(depth) bits wide.
   always_comb begin
      mem_d = mem_q;
      for (int p = 0; p < NUM_PORTS; p++) begin
         wptr_d[p]  = wptr_q[p];
         rptr_d[p]  = rptr_q[p];
         if (push[p]) begin
            mem_d[p][wptr_q[p]] = bus.bus_port_data_i[p*DATA_WIDTH +: DATA_WIDTH];
            wptr_d[p]           = wptr_q[p] + PTR_W'(1);
         end
         if (pop[p]) begin
            rptr_d[p] = rptr_q[p] + PTR_W'(1);
         end
         count_d[p] = count_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
      end
   end

   // Output stage next state. Data and id hold during a stall and after the output drains.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      id_d    = id_q;
      last_d  = last_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = sel_data;
         id_d    = grant;
         last_d  = grant;
      end else if (bus.bus_ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Control and output registers. Reset empties every FIFO and clears the output.
   always_ff @(posedge bus_clock or negedge bus_reset_n) begin
      if (!bus_reset_n) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            wptr_q[p]  <= '0;
            rptr_q[p]  <= '0;
            count_q[p] <= '0;
         end
         valid_q <= 1'b0;
         data_q  <= '0;
         id_q    <= '0;
         last_q  <= LAST_RST;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         id_q    <= id_d;
         last_q  <= last_d;
      end
   end

   // FIFO storage needs no reset; the counts decide which entries are live
   always_ff @(posedge bus_clock) begin
      mem_q <= mem_d;
   end

   assign bus.bus_port_ready_o = ready;
   assign bus.bus_valid_o      = valid_q;
   assign bus.bus_data_o       = data_q;
   assign bus.bus_port_id_o    = id_q;

endmodule

// File: tb/tb_w0rm_peripheral_bus_merger.sv
// Directed bench for w0rm_peripheral_bus_merger.
// Instance A: 4 ports, round-robin. Instance B: 3 ports, round-robin.
// Instance C: 2 ports, fixed priority.
module tb_w0rm_peripheral_bus_merger;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   w0rm_peripheral_bus_merger_if #(.DATA_WIDTH(32), .NUM_PORTS(4)) ifa ();
   w0rm_peripheral_bus_merger_if #(.DATA_WIDTH(32), .NUM_PORTS(3)) ifb ();
   w0rm_peripheral_bus_merger_if #(.DATA_WIDTH(32), .NUM_PORTS(2)) ifc ();

   w0rm_peripheral_bus_merger #(.DATA_WIDTH(32), .NUM_PORTS(4), .FIFO_DEPTH(2), .ARB_MODE(1)) dut_a (
      .bus_clock(clk), .bus_reset_n(rst_n), .bus(ifa));
   w0rm_peripheral_bus_merger #(.DATA_WIDTH(32), .NUM_PORTS(3), .FIFO_DEPTH(2), .ARB_MODE(1)) dut_b (
      .bus_clock(clk), .bus_reset_n(rst_n), .bus(ifb));
   w0rm_peripheral_bus_merger #(.DATA_WIDTH(32), .NUM_PORTS(2), .FIFO_DEPTH(2), .ARB_MODE(0)) dut_c (
      .bus_clock(clk), .bus_reset_n(rst_n), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   logic [7:0] rr_data [6];
   logic [2:0] rr_id   [6];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      ifa.bus_port_valid_i = '0; ifa.bus_port_data_i = '0; ifa.bus_ready_i = 1'b0;
      ifb.bus_port_valid_i = '0; ifb.bus_port_data_i = '0; ifb.bus_ready_i = 1'b0;
      ifc.bus_port_valid_i = '0; ifc.bus_port_data_i = '0; ifc.bus_ready_i = 1'b0;
      rr_data = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
      rr_id   = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};

      // ---- power-on reset values
      step(); step();
      chk("por_valid", ifa.bus_valid_o, 0);
      chk("por_data",  ifa.bus_data_o, 0);
      chk("por_id",    ifa.bus_port_id_o, 0);
      chk("por_ready_a", ifa.bus_port_ready_o, 4'hF);
      chk("por_ready_b", ifb.bus_port_ready_o, 3'h7);
      chk("por_ready_c", ifc.bus_port_ready_o, 2'h3);
      rst_n = 1'b1;
      step();

      // ---- single word on port 2, no bypass
      ifa.bus_port_valid_i[2] = 1'b1;
      ifa.bus_port_data_i[2*32 +: 32] = 32'hDEADBEEF;
      step();                                   // edge k pushed
      ifa.bus_port_valid_i = '0;
      chk("single_no_bypass", ifa.bus_valid_o, 0);
      step();                                   // edge k+1 loads output
      chk("single_valid", ifa.bus_valid_o, 1);
      chk("single_data",  ifa.bus_data_o, 32'hDEADBEEF);
      chk("single_id",    ifa.bus_port_id_o, 2);
      ifa.bus_ready_i = 1'b1;
      step();
      chk("single_drain_valid", ifa.bus_valid_o, 0);
      chk("single_drain_data",  ifa.bus_data_o, 32'hDEADBEEF);
      chk("single_drain_id",    ifa.bus_port_id_o, 2);

      // ---- backpressure and full FIFO on port 0
      ifa.bus_ready_i = 1'b0;
      ifa.bus_port_valid_i[0] = 1'b1;
      ifa.bus_port_data_i[0 +: 32] = 32'h1;
      step();                                   // 0x1 into FIFO
      ifa.bus_port_data_i[0 +: 32] = 32'h2;
      step();                                   // 0x2 in, 0x1 to output
      chk("bp_out1",   ifa.bus_data_o, 32'h1);
      chk("bp_ready1", ifa.bus_port_ready_o[0], 1);
      ifa.bus_port_data_i[0 +: 32] = 32'h3;
      step();                                   // 0x3 in, FIFO full
      chk("bp_full",   ifa.bus_port_ready_o[0], 0);
      ifa.bus_port_data_i[0 +: 32] = 32'h4;
      step();                                   // 0x4 held by producer
      chk("bp_hold_ready", ifa.bus_port_ready_o[0], 0);
      chk("bp_hold_valid", ifa.bus_valid_o, 1);
      chk("bp_hold_data",  ifa.bus_data_o, 32'h1);
      ifa.bus_ready_i = 1'b1;
      step();                                   // first pop: 0x2 out
      chk("bp_drain2", ifa.bus_data_o, 32'h2);
      chk("bp_ready_back", ifa.bus_port_ready_o[0], 1);
      step();                                   // 0x4 accepted, 0x3 out
      ifa.bus_port_valid_i = '0;
      chk("bp_drain3", ifa.bus_data_o, 32'h3);
      step();
      chk("bp_drain4", ifa.bus_data_o, 32'h4);
      chk("bp_drain4_id", ifa.bus_port_id_o, 0);
      step();
      chk("bp_empty", ifa.bus_valid_o, 0);

      // ---- stall stability: last grant is port 0, ports 0,1,3 pending
      ifa.bus_ready_i = 1'b0;
      ifa.bus_port_valid_i = 4'b1011;
      ifa.bus_port_data_i[0*32 +: 32] = 32'h33;
      ifa.bus_port_data_i[1*32 +: 32] = 32'h55;
      ifa.bus_port_data_i[3*32 +: 32] = 32'h77;
      step();
      ifa.bus_port_valid_i = '0;
      step();                                   // round-robin after port 0 -> port 1
      ifa.bus_port_valid_i[2] = 1'b1;
      ifa.bus_port_data_i[2*32 +: 32] = 32'h22;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", ifa.bus_valid_o, 1);
         chk("stall_data",  ifa.bus_data_o, 32'h55);
         chk("stall_id",    ifa.bus_port_id_o, 1);
         step();
         ifa.bus_port_valid_i = '0;
      end
      ifa.bus_ready_i = 1'b1;
      step();                                   // pointer still 1 -> port 2 next
      ifa.bus_ready_i = 1'b0;
      chk("stall_rr_data", ifa.bus_data_o, 32'h22);
      chk("stall_rr_id",   ifa.bus_port_id_o, 2);

      // ---- reset mid-stream with 0x33 and 0x77 still buffered
      rst_n = 1'b0;
      ifa.bus_port_valid_i[1] = 1'b1;
      ifa.bus_port_data_i[1*32 +: 32] = 32'h99;
      #1;
      chk("rst_valid", ifa.bus_valid_o, 0);
      chk("rst_data",  ifa.bus_data_o, 0);
      chk("rst_id",    ifa.bus_port_id_o, 0);
      chk("rst_ready", ifa.bus_port_ready_o, 4'hF);
      step(); step();
      ifa.bus_port_valid_i = '0;
      rst_n = 1'b1;
      ifa.bus_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rst_no_stale", ifa.bus_valid_o, 0);
      end
      chk("rst_ready_after", ifa.bus_port_ready_o, 4'hF);

      // ---- round-robin order on instance B
      ifb.bus_ready_i = 1'b0;
      ifb.bus_port_valid_i = 3'b111;
      ifb.bus_port_data_i = {32'hA2, 32'hA1, 32'hA0};
      step();
      ifb.bus_port_data_i = {32'hB2, 32'hB1, 32'hB0};
      step();                                   // 0xA0 loaded into output
      ifb.bus_port_valid_i = '0;
      ifb.bus_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("rr_data", ifb.bus_data_o, 64'(rr_data[i]));
         chk("rr_id",   ifb.bus_port_id_o, 64'(rr_id[i]));
         step();
      end
      chk("rr_empty", ifb.bus_valid_o, 0);

      // ---- fixed priority on instance C
      ifc.bus_ready_i = 1'b1;
      ifc.bus_port_valid_i = 2'b11;
      ifc.bus_port_data_i = {32'h11, 32'h01};
      step();
      ifc.bus_port_valid_i = 2'b01;
      ifc.bus_port_data_i[0 +: 32] = 32'h02;
      step();
      chk("fp_1", ifc.bus_data_o, 32'h01);
      ifc.bus_port_data_i[0 +: 32] = 32'h03;
      step();
      ifc.bus_port_valid_i = '0;
      chk("fp_2", ifc.bus_data_o, 32'h02);
      step();
      chk("fp_3", ifc.bus_data_o, 32'h03);
      step();
      chk("fp_4_data", ifc.bus_data_o, 32'h11);
      chk("fp_4_id",   ifc.bus_port_id_o, 1);
      step();
      chk("fp_empty", ifc.bus_valid_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/w0rm_peripheral_bus_merger.md
# w0rm_peripheral_bus_merger

Parametrised N-port merge point for the W0RM peripheral bus, replacing the fixed two-port pass-through mux. Each input port gets a small FIFO with a valid/ready handshake. A fixed-priority or round-robin arbiter drains the FIFOs into one registered output stage with downstream backpressure. It sits between several peripheral response sources and the single bus return path into the core, and tags every output word with its source port.

## Interface
- DATA_WIDTH, 32, width of one bus word
- NUM_PORTS, 2, number of input ports; legal range 2..8
- FIFO_DEPTH, 2, words per input FIFO; power of two, >= 2
- ARB_MODE, 1, 0 = fixed priority (port 0 highest), 1 = round-robin
- bus_clock  in  1  single clock; all state changes on rising edge
- bus_reset_n  in  1  asynchronous, active-low reset
- bus_port_valid_i  in  NUM_PORTS  per-port word valid; bit p = port p
- bus_port_data_i  in  NUM_PORTS*DATA_WIDTH  flattened data; port p at [p*DATA_WIDTH +: DATA_WIDTH]
- bus_port_ready_o  out  NUM_PORTS  per-port FIFO not full
- bus_valid_o  out  1  output word valid
- bus_data_o  out  DATA_WIDTH  output word
- bus_port_id_o  out  3  source port index of bus_data_o
- bus_ready_i  in  1  downstream accepts the output word

## Operation
- **Reset (bus_reset_n low).**
  - All FIFOs are emptied.
  - bus_valid_o = 0, bus_data_o = 0, bus_port_id_o = 0.
  - The round-robin pointer is set to NUM_PORTS-1, so port 0 wins first.
  - bus_port_ready_o = all ones, because ready reflects not-full.
  - Pushes presented during reset are dropped.
  - A reset in mid-transfer discards all buffered and output words, with no partial state left.
- **Push.**
  - Port p writes on a rising edge when bus_port_valid_i[p] && bus_port_ready_o[p].
  - bus_port_ready_o[p] = (count_p != FIFO_DEPTH) and depends only on registered state, with no combinational path from bus_ready_i.
  - A full FIFO does not accept a push in the same cycle it is popped; ready rises on the following cycle.
  - If valid is high while ready is low, the producer holds its word. The block never drops an accepted word.
- **Load condition.**
  - The output register loads when (!bus_valid_o || bus_ready_i) and at least one FIFO is non-empty.
  - The granted FIFO is popped on that same edge.
- **Arbitration.**
  - ARB_MODE 0: grant the lowest-index non-empty FIFO.
  - ARB_MODE 1: search from (last_grant+1) mod NUM_PORTS upward, wrapping, and grant the first non-empty FIFO. last_grant updates only when a load occurs.
- **Output hold.** While bus_valid_o && !bus_ready_i, bus_data_o and bus_port_id_o are stable and no FIFO is popped.
- **Output drain.** If bus_ready_i is high and all FIFOs are empty, bus_valid_o falls on the next edge. bus_data_o and bus_port_id_o keep their last values.
- **Simultaneous push and pop on one FIFO** (not full): the count is unchanged and ordering is preserved.
- **Pointer wrap.** FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.
- **Ordering.** Words from any one port leave in arrival order. No ordering is guaranteed between ports.

## Timing
- Latency: a word pushed on edge k into an empty block with an idle output is valid on bus_valid_o after edge k+1. There is no bypass path.
- Throughput: 1 word per cycle aggregate when bus_ready_i is held high.
- Round-robin fairness: with all ports continuously non-empty, each port is granted exactly once per NUM_PORTS loads.
- Fixed priority: port p can starve while any lower-index port stays non-empty. This is by design.
- bus_port_ready_o changes only on clock edges or on reset assertion.

## Test plan
- **Reset values:** assert bus_reset_n low mid-stream with 2 words buffered, then release.
  - Required: bus_valid_o=0, bus_data_o=0, bus_port_id_o=0, ready=all ones.
  - Required: no buffered word ever appears on the output afterwards.
- **Single word:** NUM_PORTS=4; push 0xDEADBEEF on port 2 at edge k.
  - Required: bus_valid_o=1, data=0xDEADBEEF, id=2 after edge k+1; valid drops one edge after bus_ready_i=1.
- **Round-robin:** ARB_MODE=1, NUM_PORTS=3; preload 2 words in each port (values 0xA0+p, 0xB0+p); hold bus_ready_i=1.
  - Required output order of ids: 0,1,2,0,1,2.
  - Required data order: 0xA0,0xA1,0xA2,0xB0,0xB1,0xB2.
- **Fixed priority:** ARB_MODE=0; port 1 preloaded with 0x11; port 0 pushes 0x01,0x02,0x03 back to back.
  - Required: 0x01,0x02,0x03 appear before 0x11.
- **Backpressure and full:** FIFO_DEPTH=2; bus_ready_i=0; port 0 pushes 0x1,0x2,0x3.
  - Required: the output holds 0x1.
  - Required: the FIFO takes 0x2 and 0x3; the next push sees bus_port_ready_o[0]=0 and is held.
  - Then raise bus_ready_i. Required: 0x1..0x3 drain in order, ready returns to 1 one cycle after the first pop, and the held word is accepted.
- **Stall stability:** bus_ready_i low for 5 cycles with valid high.
  - Required: data and id are bit-stable and the round-robin pointer is unchanged.
